// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the control section (port 0) and a secondary master (port 1).
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 always wins ties.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [2:0]        mt0,
    input  logic [2:0]        mt1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              gnt,
    output logic              busy_o,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ld,
    output logic              mem_wr,
    output logic [2:0]        mem_mt,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_reg, state_next;
    logic                gnt_reg;
    logic                wr_reg;
    logic [2:0]          mt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [1:0]          err_reg;
    logic                win;
    logic                timeout_hit;
`ifdef MEM_ARB_RR_EN
    logic                ptr_reg;
`endif

    // Winner of the current IDLE arbitration; a lone request always wins.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        win = (req0 && req1) ? ptr_reg : req1;
`else
        win = ~req0;
`endif
    end

    assign timeout_hit = mem_busy && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req0 || req1) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT: begin
                if (!mem_busy) begin
                    state_next = RESP;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command capture, read-data capture, timeout counter and the registered abort pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_reg   <= 1'b0;
            wr_reg    <= 1'b0;
            mt_reg    <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            cnt_reg   <= '0;
            err_reg   <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_reg   <= 1'b0;
`endif
        end else begin
            err_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_reg   <= win;
                        wr_reg    <= win ? wr1    : wr0;
                        mt_reg    <= win ? mt1    : mt0;
                        addr_reg  <= win ? addr1  : addr0;
                        wdata_reg <= win ? wdata1 : wdata0;
`ifdef MEM_ARB_RR_EN
                        ptr_reg   <= ~win;
`endif
                    end
                end
                WAIT: begin
                    cnt_reg <= timeout_hit ? '0 : cnt_reg + 1'b1;
                    if (!mem_busy && !wr_reg) begin
                        rdata_reg <= mem_rdata;
                    end
                    if (timeout_hit) begin
                        err_reg[gnt_reg] <= 1'b1;
                    end
                end
                RESP:    cnt_reg <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_ld = 1'b0;
        mem_wr = 1'b0;
        ack0   = 1'b0;
        ack1   = 1'b0;
        if (state_reg == ISSUE) begin
            mem_ld = ~wr_reg;
            mem_wr = wr_reg;
        end
        if (state_reg == RESP) begin
            ack0 = ~gnt_reg;
            ack1 = gnt_reg;
        end
        busy_o = (state_reg != IDLE);
    end

    assign err0      = err_reg[0];
    assign err1      = err_reg[1];
    assign gnt       = gnt_reg;
    assign rdata     = rdata_reg;
    assign mem_addr  = addr_reg;
    assign mem_mt    = mt_reg;
    assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences
// and randomized transactions checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int KEEP = 0, DROP_OWN = 1, DROP_ALL = 2;

    typedef struct packed {
        logic          wr;
        logic [2:0]    mt;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        int            port;
        txn_t          t;
        int            blen;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic [2:0]    mt0 = '0, mt1 = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, err0, err1, gnt, busy_o, mem_ld, mem_wr, mem_busy;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_mt;
    logic [106:0]  all_outs;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1), .mt0(mt0), .mt1(mt1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .gnt(gnt), .busy_o(busy_o), .mem_addr(mem_addr), .mem_ld(mem_ld), .mem_wr(mem_wr),
        .mem_mt(mem_mt), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    assign all_outs = {ack0, ack1, err0, err1, gnt, busy_o, mem_ld, mem_wr,
                       mem_mt, rdata, mem_addr, mem_wdata};

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hDEADBEEF + DW'(i) * 32'h11111111;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory environment: 16-word array, busy for blen_cur cycles after each strobe.
    logic [DW-1:0] mem_arr [16];
    logic [3:0]    lat_idx = '0;
    int            busy_cnt = 0;
    int            blen_cur = 0;
    bit            stuck = 1'b0;
    bit            mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
        end else if (mem_ld || mem_wr) begin
            lat_idx <= mem_addr[5:2];
            if (mem_wr) mem_arr[mem_addr[5:2]] <= mem_wdata;
            busy_cnt <= blen_cur;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign mem_busy  = stuck || (busy_cnt != 0);
    assign mem_rdata = mem_arr[lat_idx];

    // Per-cycle protocol checks and strobe capture.
    int            n_strobe = 0;
    logic          st_ld = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [2:0]    st_mt = '0;
    logic [DW-1:0] st_wdata = '0;
    logic          p_busy = 1'b0, p_ack = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [2:0]    p_mt = '0;
    logic [DW-1:0] p_wdata = '0;

    always @(negedge clk) begin
        if (mem_ld || mem_wr) begin
            n_strobe <= n_strobe + 1;
            st_ld    <= mem_ld;
            st_addr  <= mem_addr;
            st_mt    <= mem_mt;
            st_wdata <= mem_wdata;
            check("strobe_only_in_issue", 128'({busy_o, p_busy, mem_ld && mem_wr}), 128'(3'b100));
        end
        check("ack_err_exclusive", 128'((ack0 && ack1) || ((ack0 || ack1) && (err0 || err1))), 128'(0));
        if (busy_o && !(ack0 || ack1) && p_busy && !p_ack) begin
            check("cmd_stable_in_wait", 128'({mem_addr, mem_mt, mem_wdata}), 128'({p_addr, p_mt, p_wdata}));
        end
        p_busy  <= busy_o;
        p_ack   <= ack0 || ack1;
        p_addr  <= mem_addr;
        p_mt    <= mem_mt;
        p_wdata <= mem_wdata;
    end

    // Reference model: memory contents, last load data and the round-robin preference.
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] ref_rdata;
`ifdef MEM_ARB_RR_EN
    bit            ref_ptr;
`endif

    function automatic bit model_pick(input bit w0, input bit w1);
`ifdef MEM_ARB_RR_EN
        return (w0 && w1) ? ref_ptr : w1;
`else
        return (w0 && w1) ? 1'b0 : w1;
`endif
    endfunction

    task automatic model_apply(input bit p, input txn_t t, input bit timed_out);
`ifdef MEM_ARB_RR_EN
        ref_ptr = ~p;
`endif
        if (!timed_out) begin
            if (t.wr) ref_mem[t.addr[5:2]] = t.wdata;
            else      ref_rdata = ref_mem[t.addr[5:2]];
        end
    endtask

    task automatic set_port(input int p, input txn_t t);
        if (p == 0) begin
            req0 = 1'b1; wr0 = t.wr; mt0 = t.mt; addr0 = t.addr; wdata0 = t.wdata;
        end else begin
            req1 = 1'b1; wr1 = t.wr; mt1 = t.mt; addr1 = t.addr; wdata1 = t.wdata;
        end
    endtask

    function automatic txn_t mk_txn(input bit wr, input logic [2:0] mt,
                                    input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        txn_t t;
        t.wr = wr; t.mt = mt; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        return mk_txn(1'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), AW'($urandom), DW'($urandom));
    endfunction

    function automatic vec_t mk_vec(input int port, input txn_t t, input int blen,
                                    input int lat, input logic [DW-1:0] rd);
        vec_t v;
        v.port = port; v.t = t; v.blen = blen; v.exp_lat = lat; v.exp_rdata = rd;
        return v;
    endfunction

    // Waits for the next ack/err (latency counted in cycles from the call) and checks the transaction.
    task automatic expect_done(input int p, input txn_t t, input int exp_lat, input bit exp_err,
                               input logic [DW-1:0] exp_rdata, input int drop, input string tag);
        int c;
        int s0;
        bit hit;
        hit = 1'b0;
        s0 = n_strobe;
        for (c = 1; c <= exp_lat + 20; c++) begin
            @(negedge clk);
            if (ack0 || ack1 || err0 || err1) begin
                hit = 1'b1;
                break;
            end
        end
        check({tag, "_completed"}, 128'(hit), 128'(1));
        if (hit) begin
            check({tag, "_latency"}, 128'(c), 128'(exp_lat));
            if (exp_err) check({tag, "_resp"}, 128'({ack0, ack1, err0, err1}), 128'(p == 0 ? 4'b0010 : 4'b0001));
            else         check({tag, "_resp"}, 128'({ack0, ack1, err0, err1}), 128'(p == 0 ? 4'b1000 : 4'b0100));
            if (!exp_err) check({tag, "_gnt"}, 128'({busy_o, gnt}), 128'({1'b1, p[0]}));
            check({tag, "_rdata"}, 128'(rdata), 128'(exp_rdata));
            check({tag, "_strobe"}, 128'({n_strobe - s0, st_ld, st_addr, st_mt, st_wdata}),
                  128'({32'd1, ~t.wr, t.addr, t.mt, t.wdata}));
        end
        if (drop == DROP_ALL) begin
            req0 = 1'b0; req1 = 1'b0;
        end else if (drop == DROP_OWN) begin
            if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        txn_t ta, tb, tx;
        bit   first, w0, w1;
        int   sel;
        logic [3:0] gseq;

        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        ref_rdata = '0;
`ifdef MEM_ARB_RR_EN
        ref_ptr = 1'b0;
`endif
        vecs[0] = mk_vec(0, mk_txn(1'b0, 3'd0, 32'h100, 32'h0),        3, 6, 32'hDEADBEEF);
        vecs[1] = mk_vec(1, mk_txn(1'b1, 3'd2, 32'h40,  32'h12345678), 0, 3, 32'hDEADBEEF);
        vecs[2] = mk_vec(0, mk_txn(1'b0, 3'd5, 32'h40,  32'h0),        1, 4, 32'h12345678);
        vecs[3] = mk_vec(1, mk_txn(1'b0, 3'd4, 32'h104, 32'h0),        2, 5, 32'hEFBED000);
        vecs[4] = mk_vec(0, mk_txn(1'b1, 3'd1, 32'h108, 32'hCAFEF00D), 2, 5, 32'hEFBED000);
        vecs[5] = mk_vec(1, mk_txn(1'b0, 3'd6, 32'h8,   32'h0),        0, 3, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        check("reset_outputs", 128'(all_outs), 128'(0));
        reset = 1'b0;
        mem_init = 1'b0;

        // Directed single transactions.
        foreach (vecs[i]) begin
            @(negedge clk);
            blen_cur = vecs[i].blen;
            set_port(vecs[i].port, vecs[i].t);
            model_apply(vecs[i].port[0], vecs[i].t, 1'b0);
            expect_done(vecs[i].port, vecs[i].t, vecs[i].exp_lat, 1'b0, vecs[i].exp_rdata,
                        DROP_OWN, $sformatf("vec%0d", i));
        end

        // Both requests held for four back-to-back transactions.
        @(negedge clk);
        blen_cur = 1;
        ta = mk_txn(1'b0, 3'd3, 32'h10, 32'h0);
        tb = mk_txn(1'b0, 3'd4, 32'h14, 32'h0);
        set_port(0, ta);
        set_port(1, tb);
        gseq = '0;
        for (int k = 0; k < 4; k++) begin
            first = model_pick(1'b1, 1'b1);
            model_apply(first, first ? tb : ta, 1'b0);
            expect_done(int'(first), first ? tb : ta, (k == 0) ? 4 : 5, 1'b0, ref_rdata,
                        (k == 3) ? DROP_ALL : KEEP, $sformatf("both%0d", k));
            gseq[k] = ack1;
        end
`ifdef MEM_ARB_RR_EN
        check("both_gnt_sequence", 128'(gseq), 128'(4'b1010));
`else
        check("both_gnt_sequence", 128'(gseq), 128'(4'b0000));
`endif

        // Memory busy stuck high: abort after TMO wait cycles, then a normal transaction.
        @(negedge clk);
        blen_cur = 0;
        stuck = 1'b1;
        tx = mk_txn(1'b0, 3'd2, 32'h20, 32'h0);
        set_port(0, tx);
        model_apply(1'b0, tx, 1'b1);
        expect_done(0, tx, 2 + TMO, 1'b1, ref_rdata, DROP_OWN, "timeout");
        stuck = 1'b0;
        @(negedge clk);
        check("timeout_single_pulse", 128'({err0, err1, busy_o}), 128'(0));
        blen_cur = 2;
        tx = mk_txn(1'b0, 3'd0, 32'h104, 32'h0);
        set_port(1, tx);
        model_apply(1'b1, tx, 1'b0);
        expect_done(1, tx, 5, 1'b0, ref_rdata, DROP_OWN, "after_timeout");

        // Reset while waiting on memory.
        @(negedge clk);
        blen_cur = 5;
        tx = mk_txn(1'b0, 3'd1, 32'h0c, 32'h0);
        set_port(0, tx);
        repeat (3) @(negedge clk);
        check("in_wait_before_reset", 128'({busy_o, mem_ld || mem_wr, ack0 || ack1}), 128'(3'b100));
        reset = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        check("reset_mid_wait", 128'(all_outs), 128'(0));
        reset = 1'b0;
        ref_rdata = '0;
`ifdef MEM_ARB_RR_EN
        ref_ptr = 1'b0;
`endif
        repeat (8) begin
            @(negedge clk);
            check("quiet_after_reset", 128'({ack0, ack1, err0, err1, busy_o}), 128'(0));
        end
        blen_cur = 0;
        tx = mk_txn(1'b0, 3'd0, 32'h0c, 32'h0);
        set_port(1, tx);
        model_apply(1'b1, tx, 1'b0);
        expect_done(1, tx, 3, 1'b0, ref_rdata, DROP_OWN, "after_reset");

        // Randomized single and simultaneous requests against the model.
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            sel = int'($urandom_range(3, 1));
            w0 = (sel & 1) != 0;
            w1 = (sel & 2) != 0;
            blen_cur = int'($urandom_range(3, 0));
            ta = rand_txn();
            tb = rand_txn();
            if (w0) set_port(0, ta);
            if (w1) set_port(1, tb);
            first = model_pick(w0, w1);
            model_apply(first, first ? tb : ta, 1'b0);
            expect_done(int'(first), first ? tb : ta, 3 + blen_cur, 1'b0, ref_rdata, DROP_OWN,
                        $sformatf("rnd%0d_a", it));
            if (w0 && w1) begin
                model_apply(~first, first ? ta : tb, 1'b0);
                expect_done(int'(~first), first ? ta : tb, 4 + blen_cur, 1'b0, ref_rdata, DROP_OWN,
                            $sformatf("rnd%0d_b", it));
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
